// File: rtl/filter_tg_pkg.sv
// Shared definitions for the filter timing / test-pattern generator.
//   - tg_state_e   : run-control FSM encoding (idle / run / stop pending)
//   - tg_pattern_e : pattern select codes carried on i_pattern_sel
//   - bar_color()  : 8-entry colour-bar Y/U/V table (white .. black)
//   - LFSR seed, tap mask and step function used when FILTER_TG_PRBS_EN is defined
package filter_tg_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopPend = 2'd2
  } tg_state_e;

  typedef enum logic [1:0] {
    PatRamp    = 2'd0,
    PatBars    = 2'd1,
    PatChecker = 2'd2,
    PatFrame   = 2'd3
  } tg_pattern_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv8_t;

  localparam logic [7:0] MidLevel = 8'd128;
  localparam logic [7:0] ChkHigh  = 8'd235;
  localparam logic [7:0] ChkLow   = 8'd16;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic yuv8_t bar_color(input logic [2:0] idx);
    yuv8_t c;
    unique case (idx)
      3'd0: c = '{y: 8'd235, u: 8'd128, v: 8'd128};  // white
      3'd1: c = '{y: 8'd210, u: 8'd16,  v: 8'd146};  // yellow
      3'd2: c = '{y: 8'd170, u: 8'd166, v: 8'd16};   // cyan
      3'd3: c = '{y: 8'd145, u: 8'd54,  v: 8'd34};   // green
      3'd4: c = '{y: 8'd106, u: 8'd202, v: 8'd222};  // magenta
      3'd5: c = '{y: 8'd81,  u: 8'd90,  v: 8'd240};  // red
      3'd6: c = '{y: 8'd41,  u: 8'd240, v: 8'd110};  // blue
      3'd7: c = '{y: 8'd16,  u: 8'd128, v: 8'd128};  // black
    endcase
    return c;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/filter_tg_pattern.sv
// Pixel data generator for filter_timing_gen. Produces registered Y/U/V for the
// raster position presented on hcnt_i/vcnt_i; outputs are zero whenever de_i is low.
// Optional macro FILTER_TG_PRBS_EN turns pattern 3 into LFSR noise instead of
// the frame-count flat field.
// Ports:
//   clk, rstn     : pixel clock, asynchronous active-low reset
//   hcnt_i/vcnt_i : current raster counters
//   de_i          : current cycle is an active pixel
//   frame_cnt_i   : frame counter (flat-field level)
//   pattern_i     : pattern in force for this frame
//   y_o/u_o/v_o   : registered pixel components
module filter_tg_pattern
  import filter_tg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned BAR_W      = 240
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CNT_WIDTH-1:0]  hcnt_i,
  input  logic [CNT_WIDTH-1:0]  vcnt_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] frame_cnt_i,
  input  tg_pattern_e           pattern_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic [DATA_WIDTH-1:0] u_o,
  output logic [DATA_WIDTH-1:0] v_o
);

  logic [2:0]            bar_idx_q, bar_idx_d, bar_idx_cur;
  logic [CNT_WIDTH-1:0]  bar_sub_q, bar_sub_d, bar_sub_cur;
  logic                  line_start;
  yuv8_t                 bar;
  logic [DATA_WIDTH-1:0] y_d, u_d, v_d;

`ifdef FILTER_TG_PRBS_EN
  logic [15:0] lfsr_q, lfsr_d, lfsr_cur;
  logic        unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt_i;
`else
  logic        unused_vcnt;
  assign unused_vcnt = ^vcnt_i;
`endif

  always_comb begin
    line_start = (hcnt_i == '0);
    // Bar position restarts combinationally on the first pixel of each line.
    bar_idx_cur = line_start ? 3'd0 : bar_idx_q;
    bar_sub_cur = line_start ? '0 : bar_sub_q;
    if (bar_sub_cur == CNT_WIDTH'(BAR_W - 1)) begin
      bar_sub_d = '0;
      bar_idx_d = bar_idx_cur + 3'd1;
    end else begin
      bar_sub_d = bar_sub_cur + CNT_WIDTH'(1);
      bar_idx_d = bar_idx_cur;
    end
    bar = bar_color(bar_idx_cur);

`ifdef FILTER_TG_PRBS_EN
    lfsr_cur = (line_start && (vcnt_i == '0)) ? LfsrSeed : lfsr_q;
    lfsr_d   = de_i ? lfsr_step(lfsr_cur) : lfsr_cur;
`endif

    y_d = '0;
    u_d = '0;
    v_d = '0;
    if (de_i) begin
      u_d = DATA_WIDTH'(MidLevel);
      v_d = DATA_WIDTH'(MidLevel);
      unique case (pattern_i)
        PatRamp:    y_d = hcnt_i[DATA_WIDTH-1:0];
        PatBars: begin
          y_d = DATA_WIDTH'(bar.y);
          u_d = DATA_WIDTH'(bar.u);
          v_d = DATA_WIDTH'(bar.v);
        end
        PatChecker: y_d = (hcnt_i[3] ^ vcnt_i[3]) ? DATA_WIDTH'(ChkHigh) : DATA_WIDTH'(ChkLow);
`ifdef FILTER_TG_PRBS_EN
        PatFrame:   y_d = DATA_WIDTH'(lfsr_cur[7:0]);
`else
        PatFrame:   y_d = frame_cnt_i;
`endif
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_idx_q <= '0;
      bar_sub_q <= '0;
      y_o       <= '0;
      u_o       <= '0;
      v_o       <= '0;
`ifdef FILTER_TG_PRBS_EN
      lfsr_q    <= LfsrSeed;
`endif
    end else begin
      bar_idx_q <= bar_idx_d;
      bar_sub_q <= bar_sub_d;
      y_o       <= y_d;
      u_o       <= u_d;
      v_o       <= v_d;
`ifdef FILTER_TG_PRBS_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

endmodule

// File: rtl/filter_timing_gen.sv
// Video timing and test-pattern source feeding the 5x5 filter. Generates a
// vs/hs/de raster (line order: active, front porch, sync, back porch) with Y/U/V
// pattern data. All outputs are registered one cycle behind the counters.
// Optional macro FILTER_TG_PRBS_EN: pattern 3 becomes LFSR noise.
// Ports:
//   clk, rstn      : pixel clock, asynchronous active-low reset
//   i_en           : level-sensitive run request
//   i_pattern_sel  : 0 ramp, 1 colour bars, 2 checkerboard, 3 frame-count / noise
//   o_vs/o_hs/o_de : sync and data enable (active-high)
//   o_y/o_u/o_v    : pixel components
//   o_frame_done   : one-cycle pulse aligned to the last raster cycle
//   o_busy         : generator not idle
module filter_timing_gen
  import filter_tg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CNT_WIDTH      = 12,
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned H_ACTIVE       = 1920,
  parameter int unsigned H_FP           = 88,
  parameter int unsigned H_SYNC         = 44,
  parameter int unsigned H_BP           = 148,
  parameter int unsigned V_ACTIVE       = 1080,
  parameter int unsigned V_FP           = 4,
  parameter int unsigned V_SYNC         = 5,
  parameter int unsigned V_BP           = 36
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_en,
  input  logic [1:0]            i_pattern_sel,
  output logic                  o_vs,
  output logic                  o_hs,
  output logic                  o_de,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic [DATA_WIDTH-1:0] o_u,
  output logic [DATA_WIDTH-1:0] o_v,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  if ((H_TOTAL > 2 ** CNT_WIDTH) || (V_TOTAL > 2 ** CNT_WIDTH)) begin : g_cnt_range_err
    $error("H_TOTAL/V_TOTAL exceed the counter range");
  end
  if ((H_ACTIVE > 2 ** MEM_ADDR_WIDTH) || (H_ACTIVE % 8 != 0)) begin : g_h_active_err
    $error("H_ACTIVE must fit the line buffer and be a multiple of 8");
  end

  tg_state_e             state_q;
  tg_pattern_e           pattern_q, pattern_cur;
  logic [CNT_WIDTH-1:0]  hcnt_q, vcnt_q, hcnt_nxt, vcnt_nxt;
  logic [DATA_WIDTH-1:0] frame_cnt_q;
  logic                  running, h_last, v_last, frame_last, frame_start;
  logic                  de_raw, hs_raw, vs_raw;
  logic                  vs_q, hs_q, de_q, frame_done_q, busy_q;

  always_comb begin
    running     = (state_q != StIdle);
    h_last      = (hcnt_q == CNT_WIDTH'(H_TOTAL - 1));
    v_last      = (vcnt_q == CNT_WIDTH'(V_TOTAL - 1));
    frame_last  = running && h_last && v_last;
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    // The select is live on the frame's first cycle so pixel (0,0) already uses it.
    pattern_cur = frame_start ? tg_pattern_e'(i_pattern_sel) : pattern_q;

    hcnt_nxt = h_last ? '0 : hcnt_q + CNT_WIDTH'(1);
    vcnt_nxt = vcnt_q;
    if (h_last) begin
      vcnt_nxt = v_last ? '0 : vcnt_q + CNT_WIDTH'(1);
    end

    de_raw = running && (hcnt_q < CNT_WIDTH'(H_ACTIVE)) && (vcnt_q < CNT_WIDTH'(V_ACTIVE));
    hs_raw = running && (hcnt_q >= CNT_WIDTH'(H_ACTIVE + H_FP))
                     && (hcnt_q <= CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC - 1));
    vs_raw = running && (vcnt_q >= CNT_WIDTH'(V_ACTIVE + V_FP))
                     && (vcnt_q <= CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      pattern_q    <= PatRamp;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frame_cnt_q  <= '0;
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      pattern_q    <= pattern_cur;
      vs_q         <= vs_raw;
      hs_q         <= hs_raw;
      de_q         <= de_raw;
      frame_done_q <= frame_last;
      busy_q       <= running;
      if (frame_last) begin
        frame_cnt_q <= frame_cnt_q + DATA_WIDTH'(1);
      end
      unique case (state_q)
        StIdle: begin
          hcnt_q <= '0;
          vcnt_q <= '0;
          if (i_en) state_q <= StRun;
        end
        StRun: begin
          hcnt_q <= hcnt_nxt;
          vcnt_q <= vcnt_nxt;
          if (!i_en) state_q <= StStopPend;
        end
        StStopPend: begin
          hcnt_q <= hcnt_nxt;
          vcnt_q <= vcnt_nxt;
          if (i_en) begin
            state_q <= StRun;
          end else if (frame_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  filter_tg_pattern #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .BAR_W      (BAR_W)
  ) u_pattern (
    .clk         (clk),
    .rstn        (rstn),
    .hcnt_i      (hcnt_q),
    .vcnt_i      (vcnt_q),
    .de_i        (de_raw),
    .frame_cnt_i (frame_cnt_q),
    .pattern_i   (pattern_cur),
    .y_o         (o_y),
    .u_o         (o_u),
    .v_o         (o_v)
  );

  assign o_vs         = vs_q;
  assign o_hs         = hs_q;
  assign o_de         = de_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_filter_timing_gen.sv
// Bench for filter_timing_gen. Two instances share the stimulus: dut_a uses the
// 14x7 raster (V_ACTIVE=4), dut_b a 14x19 raster (V_ACTIVE=16) so the checkerboard
// reaches its second vertical cell. A frame-position model predicts every output
// each cycle; literal checks pin the model at hand-computed points.
module tb_filter_timing_gen;

  localparam int HA = 8;
  localparam int HT = 14;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic       fd;
    logic       busy;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } obs_t;

  typedef struct packed {
    int mode;  // 0 idle, 1 run, 2 stop pending
    int pos;   // cycle index within the frame
    int fcnt;
    int pat;
  } mst_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [1:0] sel;

  logic       a_vs, a_hs, a_de, a_fd, a_busy;
  logic [7:0] a_y, a_u, a_v;
  logic       b_vs, b_hs, b_de, b_fd, b_busy;
  logic [7:0] b_y, b_u, b_v;

  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  mst_t mst [2];
  obs_t exp_o [2];
  obs_t obs_a, obs_b;

  always #5 clk = ~clk;

  filter_timing_gen #(
    .DATA_WIDTH (8), .CNT_WIDTH (12), .MEM_ADDR_WIDTH (11),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_a (
    .clk (clk), .rstn (rstn), .i_en (en), .i_pattern_sel (sel),
    .o_vs (a_vs), .o_hs (a_hs), .o_de (a_de), .o_y (a_y), .o_u (a_u), .o_v (a_v),
    .o_frame_done (a_fd), .o_busy (a_busy)
  );

  filter_timing_gen #(
    .DATA_WIDTH (8), .CNT_WIDTH (12), .MEM_ADDR_WIDTH (11),
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (16), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dut_b (
    .clk (clk), .rstn (rstn), .i_en (en), .i_pattern_sel (sel),
    .o_vs (b_vs), .o_hs (b_hs), .o_de (b_de), .o_y (b_y), .o_u (b_u), .o_v (b_v),
    .o_frame_done (b_fd), .o_busy (b_busy)
  );

  assign obs_a = {a_vs, a_hs, a_de, a_fd, a_busy, a_y, a_u, a_v};
  assign obs_b = {b_vs, b_hs, b_de, b_fd, b_busy, b_y, b_u, b_v};

  function automatic int vact(input int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic logic [23:0] bar_ref(input int idx);
    case (idx)
      0: return {8'd235, 8'd128, 8'd128};
      1: return {8'd210, 8'd16, 8'd146};
      2: return {8'd170, 8'd166, 8'd16};
      3: return {8'd145, 8'd54, 8'd34};
      4: return {8'd106, 8'd202, 8'd222};
      5: return {8'd81, 8'd90, 8'd240};
      6: return {8'd41, 8'd240, 8'd110};
      default: return {8'd16, 8'd128, 8'd128};
    endcase
  endfunction

  // Noise value of the n-th active pixel of a frame.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] s;
    s = 16'hACE1;
    for (int k = 0; k < n; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  function automatic obs_t model_out(input int d, input mst_t s, input logic [1:0] sel_now);
    obs_t        o;
    int          h, v, va, vt, pat;
    logic [23:0] c;
    logic [15:0] lf;
    o = '0;
    if (s.mode == 0) return o;
    va  = vact(d);
    vt  = va + 3;
    h   = s.pos % HT;
    v   = s.pos / HT;
    pat = (s.pos == 0) ? int'(sel_now) : s.pat;
    o.busy = 1'b1;
    o.fd   = (s.pos == HT * vt - 1);
    o.hs   = (h >= 10) && (h <= 11);
    o.vs   = (v == va + 1);
    o.de   = (h < HA) && (v < va);
    if (o.de) begin
      o.u = 8'd128;
      o.v = 8'd128;
      case (pat)
        0: o.y = 8'(h);
        1: begin
          c = bar_ref(h / (HA / 8));
          o.y = c[23:16];
          o.u = c[15:8];
          o.v = c[7:0];
        end
        2: o.y = (((h >> 3) ^ (v >> 3)) & 1) != 0 ? 8'd235 : 8'd16;
        default: begin
`ifdef FILTER_TG_PRBS_EN
          lf  = lfsr_after(v * HA + h);
          o.y = lf[7:0];
`else
          lf  = '0;
          o.y = 8'(s.fcnt);
`endif
        end
      endcase
    end
    return o;
  endfunction

  function automatic mst_t model_step(input int d, input mst_t s, input logic en_now,
                                      input logic [1:0] sel_now);
    mst_t n;
    int   total;
    n     = s;
    total = HT * (vact(d) + 3);
    if (s.mode == 0) begin
      if (en_now) begin
        n.mode = 1;
        n.pos  = 0;
      end
    end else begin
      if (s.pos == 0) n.pat = int'(sel_now);
      n.pos = (s.pos + 1) % total;
      if (s.pos == total - 1) n.fcnt = (s.fcnt + 1) % 256;
      if (en_now) n.mode = 1;
      else if (s.mode == 1) n.mode = 2;
      else if (s.pos == total - 1) n.mode = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        mst[d]   <= '0;
        exp_o[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_o[d] <= model_out(d, mst[d], sel);
        mst[d]   <= model_step(d, mst[d], en, sel);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        obs_t got;
        got = (d == 0) ? obs_a : obs_b;
        n_vec++;
        if (got !== exp_o[d]) begin
          n_err++;
          $display("FAIL raster dut%0d t=%0t got=%h want=%h (vs,hs,de,fd,busy,y,u,v)",
                   d, $time, got, exp_o[d]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int bar_y [8];
    int bar_u [8];
    int fc_y;
    bar_y = '{235, 210, 170, 145, 106, 81, 41, 16};
    bar_u = '{128, 16, 166, 54, 202, 90, 240, 128};
    rstn = 1'b1;
    en   = 1'b0;
    sel  = 2'd0;
    #2 rstn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_de", a_de, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_y", b_y, 0);
    rstn = 1'b1;
    en   = 1'b1;

    // Phase 1: continuous run, pattern changes, then a graceful stop.
    @(posedge clk);  // edge 0
    for (int c = 1; c <= 810; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        chk("ramp_de_first", a_de, 1);
        chk("ramp_y0", a_y, 0);
        chk("ramp_u0", a_u, 128);
        chk("ramp_v0", a_v, 128);
        chk("busy_run", a_busy, 1);
      end
      if (c == 8) chk("ramp_y7", a_y, 7);
      if (c == 9) begin
        chk("de_fall", a_de, 0);
        chk("blank_y", a_y, 0);
      end
      if (c == 10) chk("hs_before", a_hs, 0);
      if (c == 11) chk("hs_first", a_hs, 1);
      if (c == 12) chk("hs_second", a_hs, 1);
      if (c == 13) chk("hs_after", a_hs, 0);
      if (c == 70) chk("vs_before", a_vs, 0);
      if (c == 71) chk("vs_first", a_vs, 1);
      if (c == 84) chk("vs_last", a_vs, 1);
      if (c == 85) chk("vs_after", a_vs, 0);
      if (c == 97) chk("fd_early", a_fd, 0);
      if (c == 98) chk("fd_pulse", a_fd, 1);
      if (c >= 99 && c <= 106) begin
        chk("bars_y", a_y, bar_y[c-99]);
        chk("bars_u", a_u, bar_u[c-99]);
      end
      if (c == 267) chk("chk_b_line0", b_y, 16);
      if (c == 365) chk("chk_b_line7", b_y, 16);
      if (c == 379) chk("chk_b_line8_px0", b_y, 235);
      if (c == 386) chk("chk_b_line8_px7", b_y, 235);
      if (c == 387) begin
        chk("chk_b_blank_de", b_de, 0);
        chk("chk_b_blank_y", b_y, 0);
      end
      if (c == 295 || c == 393 || c == 491) begin
`ifdef FILTER_TG_PRBS_EN
        fc_y = 225;
`else
        fc_y = (c - 1) / 98;
`endif
        chk("pat3_first_px", a_y, fc_y);
      end
      if (c == 650) chk("busy_stop_pend", a_busy, 1);
      if (c == 686) begin
        chk("stop_fd", a_fd, 1);
        chk("stop_busy_hold", a_busy, 1);
      end
      if (c == 687) begin
        chk("stop_busy_fall", a_busy, 0);
        chk("stop_de_idle", a_de, 0);
      end
      if (c == 798) chk("stop_b_fd", b_fd, 1);
      if (c == 799) chk("stop_b_busy", b_busy, 0);
      if (c == 50)  sel = 2'd1;
      if (c == 150) sel = 2'd2;
      if (c == 280) sel = 2'd3;
      if (c == 600) en = 1'b0;
      if (c == 810) begin
        sel = 2'd0;
        en  = 1'b1;
      end
    end

    // Phase 2: brief stop request withdrawn, then reset mid-frame.
    @(posedge clk);  // edge 0
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 20) en = 1'b0;
      if (c == 25) en = 1'b1;
      if (c == 26) chk("resume_busy", a_busy, 1);
      if (c == 31) chk("resume_ramp_y", a_y, 2);
      if (c == 40) chk("pre_reset_hs", a_hs, 1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_hs", a_hs, 0);
    chk("async_rst_busy", a_busy, 0);
    chk("async_rst_b_busy", b_busy, 0);
    chk("async_rst_b_de", b_de, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Phase 3: restart from reset at the top of the raster.
    @(posedge clk);  // edge 0
    for (int c = 1; c <= 280; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        chk("restart_de", a_de, 1);
        chk("restart_y0", a_y, 0);
      end
      if (c == 2) chk("restart_y1", a_y, 1);
      if (c == 98) chk("restart_fd", a_fd, 1);
      if (c == 110) en = 1'b0;
      if (c == 196) chk("final_fd", a_fd, 1);
      if (c == 197) chk("final_busy", a_busy, 0);
      if (c == 266) chk("final_b_fd", b_fd, 1);
      if (c == 267) chk("final_b_busy", b_busy, 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter_timing_gen.md
Name: filter_timing_gen

Overview:
- Video timing and test-pattern source that sits directly upstream of the 5x5 filter top.
- Generates the vs/hs/de raster plus Y/U/V pixel data and drives the filter's i_vs/i_hs/i_de/i_y/i_u/i_v.
- Provides self-contained frame stimulus for bring-up, line-buffer and convolution verification without an external video source.

Parameters:
- DATA_WIDTH, 8, pixel component width.
- CNT_WIDTH, 12, width of h/v counters; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_WIDTH.
- MEM_ADDR_WIDTH, 11, filter line-buffer address width; H_ACTIVE must be ≤ 2^MEM_ADDR_WIDTH.
- H_ACTIVE, 1920, active pixels per line; must be a multiple of 8.
- H_FP / H_SYNC / H_BP, 88 / 44 / 148, horizontal front porch / sync / back porch, in pixels.
- V_ACTIVE, 1080, active lines per frame.
- V_FP / V_SYNC / V_BP, 4 / 5 / 36, vertical front porch / sync / back porch, in lines.

Ports:
- clk  in  1  pixel clock.
- rstn  in  1  asynchronous active-low reset.
- i_en  in  1  run request, level-sensitive.
- i_pattern_sel  in  2  0=ramp, 1=colour bars, 2=checkerboard, 3=frame-count flat.
- o_vs  out  1  vertical sync, active-high.
- o_hs  out  1  horizontal sync, active-high.
- o_de  out  1  data enable.
- o_y / o_u / o_v  out  DATA_WIDTH each  pixel components.
- o_frame_done  out  1  one-cycle pulse on the last cycle of each frame.
- o_busy  out  1  high while state ≠ IDLE.

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous, active-low.
- Reset: all outputs 0; state IDLE; counters, frame counter and bar counter 0. An asserted rstn mid-frame zeroes all outputs immediately; no partial frame resumes after release.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; BAR_W = H_ACTIVE/8.
- Line order: active, FP, SYNC, BP.
  - hcnt 0..H_ACTIVE-1 is active.
  - hs is high for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs is high for whole lines with vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - de = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Counter wrap: hcnt wraps at H_TOTAL-1 and then increments vcnt; vcnt wraps at V_TOTAL-1.
- State machine:
  - IDLE→RUN when i_en=1 at a clock edge; counters load 0 at that same edge.
  - RUN→STOP_PEND when i_en=0.
  - STOP_PEND→RUN when i_en=1, with no raster gap.
  - STOP_PEND→IDLE at the frame-last cycle (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1).
  - In RUN or STOP_PEND, counters advance every cycle.
  - In IDLE, counters hold 0 and all video outputs are 0.
- Latency: all outputs are registered, one cycle after counter state. o_de first rises one cycle after the IDLE→RUN edge.
- o_frame_done is registered with the video outputs and aligned to the last raster cycle.
- i_pattern_sel is sampled only when hcnt=0 and vcnt=0 (frame start); mid-frame changes are ignored.
- Frame counter increments at each frame-last cycle and wraps at 2^DATA_WIDTH.
- Pixel data while de=1:
  - Ramp: y=hcnt[DATA_WIDTH-1:0], u=v=128.
  - Bars: bar index 0..7 is advanced by a BAR_W-cycle sub-counter reset at hcnt=0. Bar (Y,U,V) values:
    - white 235,128,128
    - yellow 210,16,146
    - cyan 170,166,16
    - green 145,54,34
    - magenta 106,202,222
    - red 81,90,240
    - blue 41,240,110
    - black 16,128,128
  - Checkerboard: y=235 if hcnt[3]^vcnt[3], else 16; u=v=128.
  - Frame-count: y=frame_cnt, u=v=128.
- Pixel data while de=0: y=u=v=0.

Optional Feature:
- Macro: FILTER_TG_PRBS_EN.
- When defined, pattern 3 becomes noise:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 at reset and at every frame start, steps on each de cycle.
  - y = lfsr[7:0], u = v = 128.
- When undefined, pattern 3 is frame-count flat and no LFSR logic exists.

Decomposition:
- Package filter_tg_pkg holds:
  - the state encoding (IDLE/RUN/STOP_PEND);
  - the pattern select codes;
  - the 8-entry bar Y/U/V constant table;
  - the LFSR seed and taps.
- Sub-module filter_tg_pattern holds the bar sub-counter, LFSR and output mux. It takes hcnt/vcnt/de/frame_cnt/pattern and produces registered y/u/v.
- The top holds the FSM, counters and sync decode.

Test Plan:
Small parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); 98 cycles per frame.
- Reset then i_en=1 at edge 0, sel=0 → o_de high cycles 1..8; o_y=0..7 with u=v=128; o_hs high at line offsets 10–11; o_vs high on line 5 only; o_frame_done pulses at cycle 98.
- sel=1 → first active line o_y sequence 235,210,170,145,106,81,41,16; o_u 128,16,166,54,202,90,240,128.
- sel=2 with V_ACTIVE=16 → o_y = 16 on lines 0–7 and 235 on lines 8–15 (hcnt[3]=0 for all 8 active pixels); o_de=0 cycles give y=0.
- sel=3 over 3 frames → frame-count build: o_y=0, 1, 2 in successive frames. PRBS build: first active pixel o_y=8'hE1 every frame.
- i_en dropped mid-frame 0 → frame completes; o_busy falls after o_frame_done. Re-asserting i_en in STOP_PEND gives a continuous raster with no idle cycle.
- rstn asserted at cycle 40 → all outputs 0 that cycle. After release with i_en=1, the raster restarts at hcnt=vcnt=0.
